// File: rtl/count_hold_ctrl.sv
// Control stage for the 4-bit hold counter: synchronizes and debounces the pause/step
// buttons, detects debounced presses and runs the PAUSE/RUN/STEP FSM that drives hold.
module count_hold_ctrl #(
   parameter int unsigned DB_CYCLES = 16,
   parameter int unsigned DB_W      = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_pause,
   input  logic       btn_step,
   output logic       hold,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      PAUSE = 2'b00,
      RUN   = 2'b01,
      STEP  = 2'b10
   } state_e;

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   // Bit 0 carries the pause button, bit 1 the step button.
   logic [1:0]            s1_q, s2_q;
   logic [1:0]            db_q, db_d;
   logic [1:0]            db_prev_q;
   logic [1:0][DB_W-1:0]  cnt_q, cnt_d;
   logic [1:0]            press;
   logic [1:0]            state_raw;
   state_e                state_q;

   always_comb begin
      db_d  = db_q;
      cnt_d = cnt_q;
      for (int unsigned i = 0; i < 2; i++) begin
         if (s2_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DB_LAST) begin
            db_d[i]  = s2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
         cnt_q     <= '0;
      end else begin
         s1_q      <= {btn_step, btn_pause};
         s2_q      <= s1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         cnt_q     <= cnt_d;
      end
   end

   assign press = db_q & ~db_prev_q;

   // Pause wins over step when both presses land in the same PAUSE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PAUSE;
      end else begin
         case (state_q)
            PAUSE: begin
               if (press[0])      state_q <= RUN;
               else if (press[1]) state_q <= STEP;
            end
            RUN: begin
               if (press[0]) state_q <= PAUSE;
            end
            STEP:    state_q <= PAUSE;
            default: state_q <= PAUSE;
         endcase
      end
   end

   // Decoded from the state flops alone; the unused encoding also freezes the counter.
   assign state_raw = state_q;
   assign state     = state_raw;
   assign hold      = (state_raw == PAUSE) || (state_raw == 2'b11);

endmodule
